sync_fifo_buf: RTL and testbench
================================

// Module: sync_fifo_buf
// PURPOSE
//   Single-clock FIFO: a 2^ADDRSIZE x DATASIZE write-enabled memory plus
//   write/read pointers, occupancy counter, full/empty and almost-full/
//   almost-empty flags, a registered read port with a valid strobe, and
//   sticky overflow/underflow error flags. Used as the same-domain buffer
//   wherever producer and consumer share wclk, alongside the async FIFO path.
// PARAMETERS
//   DATASIZE      32   data word width (bits)
//   ADDRSIZE      9    address bits; DEPTH = 1<<ADDRSIZE words
//   AFULL_THRESH  DEPTH-4  almost_full asserts when count >= this
//   AEMPTY_THRESH 4    almost_empty asserts when count <= this
// PORTS
//   wclk          in   1            clock, all state on rising edge
//   wrst_n        in   1            async active-low reset
//   winc          in   1            write request
//   wdata         in   DATASIZE     write data
//   rinc          in   1            read request
//   flush         in   1            sync clear of pointers/count/rvalid
//   clr_err       in   1            sync clear of sticky error flags
//   rdata         out  DATASIZE     registered read data
//   rvalid        out  1            rdata valid strobe (1 cycle)
//   wfull         out  1            count == DEPTH
//   rempty        out  1            count == 0
//   almost_full   out  1            count >= AFULL_THRESH
//   almost_empty  out  1            count <= AEMPTY_THRESH
//   count         out  ADDRSIZE+1   current occupancy, 0..DEPTH
//   overflow      out  1            sticky: write attempted while full
//   underflow     out  1            sticky: read attempted while empty
// BEHAVIOUR
// - Reset (wrst_n=0, async): wptr=rptr=0, count=0, rdata=0, rvalid=0,
//   overflow=underflow=0; hence rempty=1, wfull=0, almost_empty=1,
//   almost_full=0. Memory contents not reset.
// - Pointers ADDRSIZE+1 bits; low ADDRSIZE bits address mem, MSB is wrap bit;
//   increment mod 2^(ADDRSIZE+1), so wrap past DEPTH-1 to 0 is seamless.
// - Write accepted (we) = winc & !wfull & !flush: mem[wptr]<=wdata, wptr++.
// - Read accepted (re) = rinc & !rempty & !flush: rdata<=mem[rptr], rptr++,
//   rvalid=1 next cycle. Latency rinc->rdata/rvalid = 1 cycle. rvalid=0 on
//   any cycle following no accepted read; rdata holds last value.
// - count next: +1 if we&!re, -1 if re&!we, unchanged if both or neither.
// - All flags are decodes of registered count: update the cycle after the
//   causing edge; no combinational path from winc/rinc to any output.
// - Full & winc & rinc: read accepted, write rejected (count -> DEPTH-1),
//   overflow set. Empty & winc & rinc: write accepted, read rejected (no
//   bypass), underflow set, rvalid=0 next cycle.
// - Read of a word written in the same cycle is impossible (empty gating);
//   read of mem[rptr] when rptr != wptr low bits always sees committed data.
// - overflow <= 1 on winc&wfull&!flush; underflow <= 1 on rinc&rempty&!flush;
//   both held until clr_err=1 (clear wins over a same-cycle set) or reset.
// - flush=1: wptr=rptr=0, count=0, rvalid=0 next cycle; winc/rinc ignored
//   that cycle; error flags and rdata unaffected.
// - Reset mid-operation: all state to reset values immediately regardless
//   of clock; in-flight read discarded (rvalid=0).
// - Thresholds: AFULL_THRESH in 1..DEPTH, AEMPTY_THRESH in 0..DEPTH-1.
// TESTING (bench uses ADDRSIZE=2, DEPTH=4, AFULL_THRESH=3, AEMPTY_THRESH=1)
// - Reset, write 0xA1,0xA2,0xA3,0xA4 -> count 1..4, almost_full at count 3,
//   wfull at 4, rempty=0 after first write, no error flags.
// - From full, 4 rinc -> rdata 0xA1..0xA4 one cycle after each rinc with
//   rvalid=1; rempty=1 and almost_empty=1 after last; then rinc ->
//   underflow=1, rvalid=0.
// - Full, winc+rinc same cycle with 0xB0 -> rdata=0xA1, count=3, overflow=1,
//   0xB0 never read back; clr_err -> overflow=0.
// - Empty, winc(0xC5)+rinc -> rvalid=0, count=1, underflow=1; next rinc ->
//   rdata=0xC5, rvalid=1.
// - Wrap: 10 cycles steady write+read at count 2 -> data order preserved
//   across pointer wrap, count stays 2.
// - Count=3, assert flush with winc+rinc -> count=0, rempty=1, rvalid=0,
//   errors unchanged; wrst_n low mid-burst -> all outputs at reset values.

Source files
------------

// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO buffer: 2^ADDRSIZE x DATASIZE memory, wrap-bit pointers,
// occupancy counter with decoded flags, registered read port and sticky errors.
module sync_fifo_buf #(
    parameter int DATASIZE      = 32,
    parameter int ADDRSIZE      = 9,
    parameter int AFULL_THRESH  = (1 << ADDRSIZE) - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rinc,
    input  logic                flush,
    input  logic                clr_err,
    output logic [DATASIZE-1:0] rdata,
    output logic                rvalid,
    output logic                wfull,
    output logic                rempty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] DEPTH_C  = (ADDRSIZE + 1)'(DEPTH);
    localparam logic [ADDRSIZE:0] AFULL_C  = (ADDRSIZE + 1)'(AFULL_THRESH);
    localparam logic [ADDRSIZE:0] AEMPTY_C = (ADDRSIZE + 1)'(AEMPTY_THRESH);
    localparam logic [ADDRSIZE:0] ONE_C    = (ADDRSIZE + 1)'(1);

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE:0]   rptr;
    logic                we;
    logic                re;
    logic                ovf_set;
    logic                unf_set;

    // Handshake: a request (winc/rinc) is accepted on the rising edge when the
    // FIFO is not full/empty and flush is low; an accepted read presents rdata
    // with rvalid high for exactly the following cycle, no backpressure on it.
    always_comb begin
        we      = winc & ~wfull & ~flush;
        re      = rinc & ~rempty & ~flush;
        ovf_set = winc & wfull & ~flush;
        unf_set = rinc & rempty & ~flush;
    end

    // Flags decode the registered count only, so no request input reaches an output.
    always_comb begin
        wfull        = (count == DEPTH_C);
        rempty       = (count == '0);
        almost_full  = (count >= AFULL_C);
        almost_empty = (count <= AEMPTY_C);
    end

    // Storage is not reset; empty gating guarantees only committed words are read.
    always_ff @(posedge wclk) begin
        if (we) begin
            mem[wptr[ADDRSIZE-1:0]] <= wdata;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (we) begin
                wptr <= wptr + ONE_C;
            end
            if (re) begin
                rptr <= rptr + ONE_C;
            end
            case ({we, re})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) begin
                rdata <= mem[rptr[ADDRSIZE-1:0]];
            end
        end
    end

    // A clear in the same cycle as a new error event wins.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end
            if (unf_set) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_buf.sv
// Randomized and directed bench for sync_fifo_buf with a queue-based reference
// model; a negedge monitor checks flags every cycle and read data against exp_q.
module tb_sync_fifo_buf;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AF_T  = 3;
    localparam int AE_T  = 1;

    logic          wclk;
    logic          wrst_n;
    logic          winc;
    logic [DW-1:0] wdata;
    logic          rinc;
    logic          flush;
    logic          clr_err;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          wfull;
    logic          rempty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    sync_fifo_buf #(
        .DATASIZE(DW),
        .ADDRSIZE(AW),
        .AFULL_THRESH(AF_T),
        .AEMPTY_THRESH(AE_T)
    ) dut (
        .wclk(wclk),
        .wrst_n(wrst_n),
        .winc(winc),
        .wdata(wdata),
        .rinc(rinc),
        .flush(flush),
        .clr_err(clr_err),
        .rdata(rdata),
        .rvalid(rvalid),
        .wfull(wfull),
        .rempty(rempty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    // clock / reset
    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // reference model state
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_rdata;
    logic          m_rvalid;
    logic          m_ovf;
    logic          m_unf;
    logic          mon_en;
    int            n_checks;
    int            n_errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_rdata  = '0;
        m_rvalid = 1'b0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
    endtask

    // One clock: drive just after a falling edge, update the model, return at the next falling edge.
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r,
                         input logic f, input logic c);
        logic was_full;
        logic was_empty;
        logic rd;
        #1;
        winc    = w;
        wdata   = d;
        rinc    = r;
        flush   = f;
        clr_err = c;
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        rd = 1'b0;
        if (f) begin
            m_q.delete();
        end else begin
            if (w && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_unf = 1'b1;
            if (r && !was_empty) begin
                rd = 1'b1;
                m_rdata = m_q.pop_front();
                exp_q.push_back(m_rdata);
            end
            if (w && !was_full) m_q.push_back(d);
        end
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        m_rvalid = rd;
        @(negedge wclk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic reset_dut();
        #1;
        winc = 1'b0; rinc = 1'b0; flush = 1'b0; clr_err = 1'b0; wdata = '0;
        wrst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_rempty", 32'(rempty), 32'd1);
        chk("rst_wfull", 32'(wfull), 32'd0);
        chk("rst_aempty", 32'(almost_empty), 32'd1);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_errs", 32'({overflow, underflow}), 32'd0);
        @(negedge wclk);
        #1 wrst_n = 1'b1;
        @(negedge wclk);
    endtask

    // scoreboard monitor
    always @(negedge wclk) begin
        if (mon_en) begin
            chk("rvalid", 32'(rvalid), 32'(m_rvalid));
            if (m_rvalid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_underrun: rvalid with rdata 0x%0h but expected queue empty", rdata);
                end else begin
                    chk("rdata_sb", 32'(rdata), 32'(exp_q.pop_front()));
                end
            end else begin
                chk("rdata_hold", 32'(rdata), 32'(m_rdata));
            end
            chk("count", 32'(count), 32'(m_q.size()));
            chk("wfull", 32'(wfull), 32'(m_q.size() == DEPTH));
            chk("rempty", 32'(rempty), 32'(m_q.size() == 0));
            chk("almost_full", 32'(almost_full), 32'(m_q.size() >= AF_T));
            chk("almost_empty", 32'(almost_empty), 32'(m_q.size() <= AE_T));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_unf));
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        mon_en   = 1'b0;
        wrst_n   = 1'b0;
        winc = 1'b0; rinc = 1'b0; flush = 1'b0; clr_err = 1'b0; wdata = '0;
        model_reset();
        @(negedge wclk);
        reset_dut();
        mon_en = 1'b1;

        // fill
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, DW'(8'hA1 + i), 1'b0, 1'b0, 1'b0);
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_rempty", 32'(rempty), 32'd0);
            chk("fill_afull", 32'(almost_full), 32'(i + 1 >= 3));
        end
        chk("fill_wfull", 32'(wfull), 32'd1);

        // drain, then underflow
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
            chk("drain_rdata", 32'(rdata), 32'(8'hA1 + i));
            chk("drain_rvalid", 32'(rvalid), 32'd1);
        end
        chk("drain_rempty", 32'(rempty), 32'd1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("unf_set", 32'(underflow), 32'd1);
        chk("unf_rvalid", 32'(rvalid), 32'd0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // full with simultaneous write and read
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(8'hA1 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hB0, 1'b1, 1'b0, 1'b0);
        chk("fullrw_rdata", 32'(rdata), 32'hA1);
        chk("fullrw_count", 32'(count), 32'd3);
        chk("fullrw_ovf", 32'(overflow), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
            chk("fullrw_drain", 32'(rdata), 32'(8'hA2 + i));
        end

        // empty with simultaneous write and read
        cycle(1'b1, 8'hC5, 1'b1, 1'b0, 1'b0);
        chk("emptyrw_rvalid", 32'(rvalid), 32'd0);
        chk("emptyrw_count", 32'(count), 32'd1);
        chk("emptyrw_unf", 32'(underflow), 32'd1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("emptyrw_rdata", 32'(rdata), 32'hC5);

        // steady state across pointer wrap
        cycle(1'b1, 8'hD0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hD1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, DW'(8'hD2 + i), 1'b1, 1'b0, 1'b0);
            chk("wrap_rdata", 32'(rdata), 32'(8'hD0 + i));
            chk("wrap_count", 32'(count), 32'd2);
        end

        // flush at count 3 with errors set
        cycle(1'b1, 8'hE0, 1'b0, 1'b0, 1'b0);
        chk("preflush_count", 32'(count), 32'd3);
        cycle(1'b1, 8'hE1, 1'b1, 1'b1, 1'b0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_rempty", 32'(rempty), 32'd1);
        chk("flush_rvalid", 32'(rvalid), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'hE2, 1'b0, 1'b1, 1'b0);
        chk("flush_keeps_unf", 32'(underflow), 32'd1);

        // reset in the middle of a burst with a read just returned
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'hF0 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hF3, 1'b1, 1'b0, 1'b0);
        mon_en = 1'b0;
        exp_q.delete();
        reset_dut();
        mon_en = 1'b1;

        // random traffic with biased phases to reach both full and empty
        for (int ph = 0; ph < 12; ph++) begin
            int wp;
            wp = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 20 : 50);
            for (int i = 0; i < 120; i++) begin
                cycle($urandom_range(0, 99) < wp,
                      DW'($urandom),
                      $urandom_range(0, 99) < (100 - wp),
                      $urandom_range(0, 99) < 2,
                      $urandom_range(0, 99) < 4);
            end
        end

        idle(3);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
